// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl: sequences one KNN classification pass.
// Per pass it clears the neighbour list, latches the test point, and fetches
// each stored point from a 1-cycle-latency memory. It issues each point over a
// valid/ready handshake, waits for the datapath to drain, and then pulses done.
// Optional build macro KNN_CTRL_PERF_EN adds a 32-bit saturating cycle counter
// (perf_cycles) that covers busy and done cycles.
module knn_seq_ctrl #(
    parameter int COORD_W   = 16,
    parameter int LABEL_W   = 8,
    parameter int ADDR_W    = 10,
    parameter int DRAIN_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_W:0]               n_points,
    input  logic [2*COORD_W-1:0]          test_point,
    output logic                          mem_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [LABEL_W+2*COORD_W-1:0]  mem_rdata,
    output logic                          dp_clear,
    output logic [2*COORD_W-1:0]          dp_test_point,
    output logic [2*COORD_W-1:0]          dp_data_point,
    output logic [LABEL_W-1:0]            dp_label,
    output logic                          dp_valid,
    input  logic                          dp_ready,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W:0]               count
`ifdef KNN_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, LOAD, ISSUE, DRAIN, DONE
    } state_t;

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    state_t                 state_reg, state_next;
    logic [ADDR_W:0]        n_lat_reg;
    logic [ADDR_W:0]        index_reg;
    logic [ADDR_W:0]        count_reg;
    logic [DW-1:0]          drain_reg;
    logic [2*COORD_W-1:0]   tp_reg;
    logic [2*COORD_W-1:0]   data_reg;
    logic [LABEL_W-1:0]     label_reg;
    logic                   accept;
    logic                   handshake;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and control outputs; abort overrides everything while busy
    always_comb begin
        state_next = state_reg;
        mem_en     = 1'b0;
        mem_addr   = '0;
        dp_clear   = 1'b0;
        dp_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = (n_points != '0) ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                dp_clear   = 1'b1;
                busy       = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                mem_en     = 1'b1;
                mem_addr   = index_reg[ADDR_W-1:0];
                busy       = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                dp_valid = 1'b1;
                busy     = 1'b1;
                if (dp_ready) begin
                    handshake  = 1'b1;
                    // Terminate on the latched count, not on address wrap
                    state_next = (index_reg == n_lat_reg - 1'b1) ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_reg == DRAIN_LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort && busy) begin
            state_next = IDLE;
            mem_en     = 1'b0;
            mem_addr   = '0;
            dp_clear   = 1'b0;
            dp_valid   = 1'b0;
            handshake  = 1'b0;
        end
    end

    // Pass bookkeeping and datapath operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat_reg <= '0;
            index_reg <= '0;
            count_reg <= '0;
            drain_reg <= '0;
            tp_reg    <= '0;
            data_reg  <= '0;
            label_reg <= '0;
        end else begin
            if (accept) begin
                n_lat_reg <= n_points;
                index_reg <= '0;
                count_reg <= '0;
                // Empty passes never enter CLEAR, so the test point is kept
                if (n_points != '0) tp_reg <= test_point;
            end
            if (state_reg == LOAD) begin
                data_reg  <= mem_rdata[2*COORD_W-1:0];
                label_reg <= mem_rdata[LABEL_W+2*COORD_W-1:2*COORD_W];
            end
            if (handshake) begin
                index_reg <= index_reg + 1'b1;
                count_reg <= count_reg + 1'b1;
            end
            if (state_reg == DRAIN) drain_reg <= drain_reg + 1'b1;
            else                    drain_reg <= '0;
        end
    end

    assign dp_test_point = tp_reg;
    assign dp_data_point = data_reg;
    assign dp_label      = label_reg;
    assign count         = count_reg;

`ifdef KNN_CTRL_PERF_EN
    logic [31:0] perf_reg;

    // Saturating count of busy/done cycles, restarted on each accepted start
    always_ff @(posedge clk) begin
        if (rst)                                       perf_reg <= '0;
        else if (accept)                               perf_reg <= '0;
        else if ((busy || done) && perf_reg != '1)     perf_reg <= perf_reg + 1'b1;
    end

    assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Directed testbench for knn_seq_ctrl (default parameters, DRAIN_CYC=2).
// Cycle 0 is the cycle in which start is driven; outputs are sampled 1ns
// after each rising edge.
module tb_knn_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [10:0] n_points;
    logic [31:0] test_point;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [39:0] mem_rdata;
    logic        dp_clear;
    logic [31:0] dp_test_point;
    logic [31:0] dp_data_point;
    logic [7:0]  dp_label;
    logic        dp_valid;
    logic        dp_ready;
    logic        busy;
    logic        done;
    logic [10:0] count;
`ifdef KNN_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    knn_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_points(n_points), .test_point(test_point),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dp_clear(dp_clear), .dp_test_point(dp_test_point),
        .dp_data_point(dp_data_point), .dp_label(dp_label),
        .dp_valid(dp_valid), .dp_ready(dp_ready),
        .busy(busy), .done(done), .count(count)
`ifdef KNN_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // Contents of the data memory: {label, x, y}
    function automatic logic [39:0] mem_word(input int a);
        logic [7:0]  l;
        logic [15:0] x;
        logic [15:0] y;
        l = 8'(a) ^ 8'hA5;
        x = 16'h1000 + 16'(a);
        y = 16'h2000 + 16'(a * 3);
        return {l, x, y};
    endfunction

    // 1-cycle-latency memory
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_word(int'(mem_addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [129:0] got;
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_points = '0;
        test_point = '0; dp_ready = 1'b1;
        tick(); tick();
        got = {mem_en, mem_addr, dp_clear, dp_test_point, dp_data_point,
               dp_label, dp_valid, busy, done, count};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_full_pass();
        logic [4:0]  got, exp;
        logic [39:0] exp_d;
        n_points = 11'd3; test_point = 32'h0005_0007; dp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            exp = {c == 1, c == 2 || c == 5 || c == 8,
                   c == 4 || c == 7 || c == 10, c == 13, c >= 1 && c <= 12};
            got = {dp_clear, mem_en, dp_valid, done, busy};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL full_ctl c=%0d got=%b exp=%b (clear,mem_en,valid,done,busy)", c, got, exp);
            end
            if (c == 2 || c == 5 || c == 8) begin
                total++;
                if (mem_addr !== 10'((c - 2) / 3)) begin
                    bad++;
                    $display("FAIL full_addr c=%0d got=%0d exp=%0d", c, mem_addr, (c - 2) / 3);
                end
            end
            if (c == 4 || c == 7 || c == 10) begin
                exp_d = mem_word((c - 4) / 3);
                total++;
                if ({dp_label, dp_data_point} !== exp_d) begin
                    bad++;
                    $display("FAIL full_data c=%0d got=%h exp=%h", c, {dp_label, dp_data_point}, exp_d);
                end
            end
            tick();
        end
        total++;
        if (count !== 11'd3 || dp_test_point !== 32'h0005_0007) begin
            bad++;
            $display("FAIL full_end count=%0d exp=3 tp=%h exp=00050007", count, dp_test_point);
        end
`ifdef KNN_CTRL_PERF_EN
        total++;
        if (perf_cycles !== 32'd13) begin
            bad++;
            $display("FAIL full_perf got=%0d exp=13", perf_cycles);
        end
        tick(); tick(); tick();
        total++;
        if (perf_cycles !== 32'd13) begin
            bad++;
            $display("FAIL full_perf_hold got=%0d exp=13", perf_cycles);
        end
`endif
        $display("full_pass: n=3 count=%0d", count);
    endtask

    task automatic test_backpressure();
        int done_cyc = -1;
        int pulses = 0;
        n_points = 11'd2; test_point = 32'h0011_0022; dp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            dp_ready = !(c >= 4 && c <= 8);
            if (c >= 4 && c <= 9) begin
                total++;
                if ({dp_valid, count, dp_label, dp_data_point} !== {1'b1, 11'd0, mem_word(0)}) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/0/%h", c, dp_valid, count,
                             {dp_label, dp_data_point}, mem_word(0));
                end
            end
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            tick();
        end
        dp_ready = 1'b1;
        total++;
        if (done_cyc != 15 || pulses != 1 || count !== 11'd2) begin
            bad++;
            $display("FAIL bp_done got cyc=%0d pulses=%0d count=%0d exp cyc=15 pulses=1 count=2",
                     done_cyc, pulses, count);
        end
        $display("backpressure: done at cycle %0d", done_cyc);
    endtask

    task automatic test_empty();
        int done_cyc = -1;
        int pulses = 0;
        int act = 0;
        n_points = 11'd0; test_point = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (dp_clear || mem_en || dp_valid || busy) act++;
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            tick();
        end
        total++;
        if (act != 0 || done_cyc != 1 || pulses != 1 || count !== 11'd0) begin
            bad++;
            $display("FAIL empty got act=%0d cyc=%0d pulses=%0d count=%0d exp 0/1/1/0",
                     act, done_cyc, pulses, count);
        end
        total++;
        if (dp_test_point !== 32'h0011_0022) begin
            bad++;
            $display("FAIL empty_tp got=%h exp=00110022", dp_test_point);
        end
        $display("empty: done at cycle %0d", done_cyc);
    endtask

    task automatic test_abort();
        int done_cyc = -1;
        n_points = 11'd4; test_point = 32'h0033_0044; dp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        total++;
        if (dp_valid !== 1'b1 || count !== 11'd1) begin
            bad++;
            $display("FAIL abort_pre got valid=%b count=%0d exp valid=1 count=1", dp_valid, count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, dp_valid, mem_en, done, count} !== {4'b0000, 11'd1}) begin
            bad++;
            $display("FAIL abort_idle got busy=%b valid=%b mem_en=%b done=%b count=%0d exp 0/0/0/0/1",
                     busy, dp_valid, mem_en, done, count);
        end
        for (int c = 0; c < 4; c++) begin
            if (done) done_cyc = c;
            tick();
        end
        total++;
        if (done_cyc != -1) begin
            bad++;
            $display("FAIL abort_nodone got done at %0d exp none", done_cyc);
        end
        // abort together with start in IDLE: abort wins
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        total++;
        if ({busy, done, dp_clear} !== 3'b000) begin
            bad++;
            $display("FAIL abort_start got busy=%b done=%b clear=%b exp 0/0/0", busy, done, dp_clear);
        end
        tick();
        n_points = 11'd1; test_point = 32'h0055_0066;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 4) begin
                total++;
                if ({dp_valid, dp_label, dp_data_point} !== {1'b1, mem_word(0)}) begin
                    bad++;
                    $display("FAIL abort_rerun_data got=%b/%h exp=1/%h", dp_valid,
                             {dp_label, dp_data_point}, mem_word(0));
                end
            end
            if (done && done_cyc < 0) done_cyc = c;
            tick();
        end
        total++;
        if (done_cyc != 7 || count !== 11'd1) begin
            bad++;
            $display("FAIL abort_rerun got cyc=%0d count=%0d exp cyc=7 count=1", done_cyc, count);
        end
        $display("abort: rerun done at cycle %0d", done_cyc);
    endtask

    task automatic test_reset_drain();
        logic [129:0] got;
        int done_cyc = -1;
        n_points = 11'd1; test_point = 32'h0077_0088; dp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        total++;
        if (busy !== 1'b1 || dp_valid !== 1'b0 || count !== 11'd1) begin
            bad++;
            $display("FAIL rst_drain_pre got busy=%b valid=%b count=%0d exp 1/0/1", busy, dp_valid, count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = {mem_en, mem_addr, dp_clear, dp_test_point, dp_data_point,
               dp_label, dp_valid, busy, done, count};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL rst_drain_zero got=%h exp=0", got);
        end
`ifdef KNN_CTRL_PERF_EN
        total++;
        if (perf_cycles !== 32'd0) begin
            bad++;
            $display("FAIL rst_drain_perf got=%0d exp=0", perf_cycles);
        end
`endif
        for (int c = 0; c < 5; c++) begin
            if (done || busy) done_cyc = c;
            tick();
        end
        total++;
        if (done_cyc != -1) begin
            bad++;
            $display("FAIL rst_drain_nodone got activity at %0d exp none", done_cyc);
        end
        $display("reset_in_drain: outputs cleared");
    endtask

    task automatic test_ignored_start();
        int done_cyc = -1;
        n_points = 11'd3; test_point = 32'h0099_00AA; dp_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) n_points = 11'd1;
            start = (c == 5) || (c == 13);
            if (done && done_cyc < 0) done_cyc = c;
            tick();
        end
        start = 1'b0;
        total++;
        if (done_cyc != 13 || count !== 11'd3) begin
            bad++;
            $display("FAIL ign_start got cyc=%0d count=%0d exp cyc=13 count=3", done_cyc, count);
        end
        $display("ignored_start: done at cycle %0d count=%0d", done_cyc, count);
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_backpressure();
        test_empty();
        test_abort();
        test_reset_drain();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
